// File: rtl/mmio_bus_if.sv
// mmio_bus_if: master-side request/response and slave-side select/ack signals of the MMIO bus.
// The bridge takes the slave modport (it is the target of the CPU master). The master modport
// is the environment's view: it issues requests and plays the part of the attached slaves.
interface mmio_bus_if #(
   parameter int unsigned N_SLV = 4
) ();
   logic               m_req;
   logic               m_we;
   logic [31:0]        m_addr;
   logic [31:0]        m_wdata;
   logic               m_ready;
   logic [31:0]        m_rdata;
   logic               m_err;
   logic [N_SLV-1:0]   s_sel;
   logic               s_we;
   logic [31:0]        s_addr;
   logic [31:0]        s_wdata;
   logic [N_SLV*32-1:0] s_rdata;
   logic [N_SLV-1:0]   s_ack;

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      output m_ready, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      input  m_ready, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
   );
endinterface

// File: rtl/mmio_bus.sv
// mmio_bus: single-master MMIO bridge. Decodes the master address onto one of N_SLV slaves,
// waits for that slave's ack with a timeout, and reports decode misses and timeouts as errors.
module mmio_bus #(
   parameter int unsigned         N_SLV    = 4,
   parameter logic [N_SLV*32-1:0] SLV_BASE = {32'hFFFF_F070, 32'hFFFF_F060,
                                              32'hFFFF_F000, 32'h0000_0000},
   parameter logic [N_SLV*32-1:0] SLV_MASK = {32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                              32'hFFFF_FFFC, 32'hFFE0_0000},
   parameter logic [N_SLV*32-1:0] SLV_OFF  = {32'h0000_0000, 32'h0000_0000,
                                              32'h0000_0000, 32'h0000_4000},
   parameter int unsigned         TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   mmio_bus_if.slave   bus,
   output logic [31:0] err_addr,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

   // Counter value seen in the last ACCESS cycle before the timeout fires
   localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

   state_e              state_q;
   logic                we_q;
   logic [31:0]         addr_q;
   logic [7:0]          tmo_q;
   logic                m_ready_q;
   logic                m_err_q;
   logic [31:0]         m_rdata_q;
   logic [N_SLV-1:0]    s_sel_q;
   logic                s_we_q;
   logic [31:0]         s_addr_q;
   logic [31:0]         s_wdata_q;
   logic [31:0]         err_addr_q;
   logic [7:0]          err_cnt_q;

   logic                hit;
   logic [N_SLV-1:0]    hit_sel;
   logic [31:0]         hit_off;
   logic                ack_sel;
   logic [31:0]         rdata_sel;

   // Address decode; scanning downward lets the lowest matching index win
   always_comb begin
      hit     = 1'b0;
      hit_sel = '0;
      hit_off = '0;
      for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
         if ((bus.m_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
            hit        = 1'b1;
            hit_sel    = '0;
            hit_sel[i] = 1'b1;
            hit_off    = SLV_OFF[i*32 +: 32];
         end
      end
   end

   // Only the selected slave's ack and read data reach the FSM
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < int'(N_SLV); i++) begin
         if (s_sel_q[i]) begin
            ack_sel   = ack_sel | bus.s_ack[i];
            rdata_sel = rdata_sel | bus.s_rdata[i*32 +: 32];
         end
      end
   end

   // Transfer FSM with all master/slave outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         addr_q     <= '0;
         tmo_q      <= '0;
         m_ready_q  <= 1'b0;
         m_err_q    <= 1'b0;
         m_rdata_q  <= '0;
         s_sel_q    <= '0;
         s_we_q     <= 1'b0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               m_ready_q <= 1'b0;
               m_err_q   <= 1'b0;
               m_rdata_q <= '0;
               if (bus.m_req) begin
                  we_q      <= bus.m_we;
                  addr_q    <= bus.m_addr;
                  s_wdata_q <= bus.m_wdata;
                  // Wraps modulo 2^32 when the offset exceeds the address
                  s_addr_q  <= bus.m_addr - hit_off;
                  if (hit) begin
                     state_q <= StAccess;
                     s_sel_q <= hit_sel;
                     s_we_q  <= bus.m_we;
                     tmo_q   <= '0;
                  end else begin
                     state_q    <= StErr;
                     m_ready_q  <= 1'b1;
                     m_err_q    <= 1'b1;
                     err_addr_q <= bus.m_addr;
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  end
               end
            end
            StAccess: begin
               if (ack_sel) begin
                  // An ack in the timeout cycle still completes the transfer
                  state_q   <= StDone;
                  m_ready_q <= 1'b1;
                  m_rdata_q <= we_q ? 32'h0 : rdata_sel;
                  s_sel_q   <= '0;
                  s_we_q    <= 1'b0;
               end else if (tmo_q == TmoLast) begin
                  state_q    <= StErr;
                  m_ready_q  <= 1'b1;
                  m_err_q    <= 1'b1;
                  s_sel_q    <= '0;
                  s_we_q     <= 1'b0;
                  err_addr_q <= addr_q;
                  if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            StDone, StErr: begin
               state_q   <= StIdle;
               m_ready_q <= 1'b0;
               m_err_q   <= 1'b0;
               m_rdata_q <= '0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.m_ready = m_ready_q;
   assign bus.m_err   = m_err_q;
   assign bus.m_rdata = m_rdata_q;
   assign bus.s_sel   = s_sel_q;
   assign bus.s_we    = s_we_q;
   assign bus.s_addr  = s_addr_q;
   assign bus.s_wdata = s_wdata_q;
   assign err_addr    = err_addr_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed transactions against a transaction-level model that predicts the
// per-cycle outputs; a negedge process compares every cycle, main flow pins literal results.
module tb_mmio_bus;
   localparam int N     = 4;
   localparam int TMO   = 15;
   localparam int NEVER = 1000;

   localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_F060,
                                        32'hFFFF_F070};
   localparam logic [31:0] MASK [4] = '{32'hFFE0_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                        32'hFFFF_FFFC};
   localparam logic [31:0] OFF  [4] = '{32'h0000_4000, 32'h0, 32'h0, 32'h0};

   typedef struct {
      logic        rdy;
      logic        er;
      logic [31:0] rd;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] sa;
      logic [31:0] swd;
      logic        cs;
      logic [7:0]  ec;
      logic [31:0] ea;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] err_addr;
   logic [7:0]  err_cnt;

   mmio_bus_if #(.N_SLV(N)) bus_if ();

   mmio_bus #(.N_SLV(N), .TIMEOUT(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .err_addr (err_addr),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        cmp_en   = 1'b0;
   exp_t        exp_q[$];
   logic [7:0]  cur_ecnt = 8'd0;
   logic [31:0] cur_eaddr = 32'h0;

   int          t0 = 0;
   logic        rdy_seen;
   int          rdy_rel;
   logic [31:0] rdy_rdata;
   logic        rdy_err;
   logic        snap_seen;
   logic [3:0]  snap_sel;
   logic        snap_we;
   logic [31:0] snap_addr;
   logic [31:0] snap_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(logic rdy, logic er, logic [31:0] rd, logic [3:0] sel, logic we,
                               logic [31:0] sa, logic [31:0] swd, logic cs, logic [7:0] ec,
                               logic [31:0] ea);
      exp_t e;
      e.rdy = rdy; e.er = er; e.rd = rd; e.sel = sel; e.we = we;
      e.sa = sa; e.swd = swd; e.cs = cs; e.ec = ec; e.ea = ea;
      return e;
   endfunction

   // Per-cycle comparison against the model queue (idle expectations when it is empty)
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, cur_ecnt, cur_eaddr);
            chk("m_ready",  32'(bus_if.m_ready), 32'(e.rdy));
            chk("m_err",    32'(bus_if.m_err),   32'(e.er));
            chk("m_rdata",  bus_if.m_rdata,      e.rd);
            chk("s_sel",    32'(bus_if.s_sel),   32'(e.sel));
            chk("s_we",     32'(bus_if.s_we),    32'(e.we));
            chk("err_cnt",  32'(err_cnt),        32'(e.ec));
            chk("err_addr", err_addr,            e.ea);
            if (e.cs) begin
               chk("s_addr",  bus_if.s_addr,  e.sa);
               chk("s_wdata", bus_if.s_wdata, e.swd);
            end
            if (bus_if.m_ready === 1'b1) begin
               rdy_seen  = 1'b1;
               rdy_rel   = cyc - t0 + 1;
               rdy_rdata = bus_if.m_rdata;
               rdy_err   = bus_if.m_err;
            end
            if (!snap_seen && bus_if.s_sel != 4'h0) begin
               snap_seen  = 1'b1;
               snap_sel   = bus_if.s_sel;
               snap_we    = bus_if.s_we;
               snap_addr  = bus_if.s_addr;
               snap_wdata = bus_if.s_wdata;
            end
         end
      end
   end

   // One transfer: waits = ACCESS cycles without ack before the ack (NEVER = no ack)
   task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rd);
      int         slv;
      int         n;
      logic       ok;
      logic [3:0] onehot;
      logic [3:0] ack;
      logic [7:0] old_cnt;
      logic [31:0] old_ea;
      slv = -1;
      for (int i = N - 1; i >= 0; i--) if ((addr & MASK[i]) == BASE[i]) slv = i;
      if (slv < 0) begin n = 0; ok = 1'b0; end
      else if (waits < TMO) begin n = waits + 1; ok = 1'b1; end
      else begin n = TMO; ok = 1'b0; end
      onehot  = (slv >= 0) ? (4'b0001 << slv) : 4'b0000;
      old_cnt = cur_ecnt;
      old_ea  = cur_eaddr;

      bus_if.m_req   = 1'b1;
      bus_if.m_we    = we;
      bus_if.m_addr  = addr;
      bus_if.m_wdata = wdata;
      rdy_seen  = 1'b0;
      snap_seen = 1'b0;
      @(posedge clk); #1;
      t0 = cyc;
      for (int k = 1; k <= n; k++)
         exp_q.push_back(mk(1'b0, 1'b0, 32'h0, onehot, we, addr - OFF[slv], wdata, 1'b1,
                            old_cnt, old_ea));
      if (!ok) begin
         cur_eaddr = addr;
         if (cur_ecnt != 8'hFF) cur_ecnt = cur_ecnt + 8'd1;
      end
      exp_q.push_back(mk(1'b1, !ok, (ok && !we) ? rd : 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0,
                         cur_ecnt, cur_eaddr));

      // Request stays high with changing master inputs; all of it must be ignored
      bus_if.m_we    = ~we;
      bus_if.m_addr  = $urandom();
      bus_if.m_wdata = $urandom();
      for (int k = 1; k <= n + 1; k++) begin
         for (int j = 0; j < N; j++)
            bus_if.s_rdata[j*32 +: 32] = (j == slv) ? rd : $urandom();
         ack = 4'($urandom()) & ~onehot;
         if (ok && k == waits + 1) ack = ack | onehot;
         bus_if.s_ack = ack;
         @(posedge clk); #1;
      end
      bus_if.m_req = 1'b0;
      bus_if.s_ack = 4'h0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected completion within time limit");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      bus_if.m_req   = 1'b0;
      bus_if.m_we    = 1'b0;
      bus_if.m_addr  = 32'h0;
      bus_if.m_wdata = 32'h0;
      bus_if.s_rdata = '0;
      bus_if.s_ack   = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_m_ready", 32'(bus_if.m_ready), 32'h0);
      chk("rst_s_sel",   32'(bus_if.s_sel),   32'h0);
      chk("rst_s_addr",  bus_if.s_addr,       32'h0);
      chk("rst_err_cnt", 32'(err_cnt),        32'h0);
      cmp_en = 1'b1;

      // Read via slave 0 with offset removal, immediate ack
      txn(32'h0000_4010, 1'b0, 32'h0, 0, 32'hDEAD_BEEF);
      chk("r0_latency", 32'(rdy_rel), 32'd2);
      chk("r0_rdata",   rdy_rdata,    32'hDEAD_BEEF);
      chk("r0_err",     32'(rdy_err), 32'h0);
      chk("r0_s_addr",  snap_addr,    32'h0000_0010);
      chk("r0_s_sel",   32'(snap_sel), 32'h1);

      // Write to slave 2 after three wait cycles
      txn(32'hFFFF_F060, 1'b1, 32'h0000_005A, 3, 32'hCAFE_F00D);
      chk("w2_s_sel",   32'(snap_sel), 32'h4);
      chk("w2_s_wdata", snap_wdata,    32'h0000_005A);
      chk("w2_s_we",    32'(snap_we),  32'h1);
      chk("w2_latency", 32'(rdy_rel),  32'd5);
      chk("w2_rdata",   rdy_rdata,     32'h0);

      // Decode miss
      txn(32'h8000_0000, 1'b0, 32'h0, 0, 32'h0);
      chk("miss_latency", 32'(rdy_rel), 32'd1);
      chk("miss_err",     32'(rdy_err), 32'h1);
      chk("miss_addr",    err_addr,     32'h8000_0000);
      chk("miss_cnt",     32'(err_cnt), 32'd1);

      // Slave 3 never acks: timeout after 15 ACCESS cycles
      txn(32'hFFFF_F070, 1'b0, 32'h0, NEVER, 32'h1111_2222);
      chk("tmo_latency", 32'(rdy_rel), 32'd16);
      chk("tmo_err",     32'(rdy_err), 32'h1);
      chk("tmo_cnt",     32'(err_cnt), 32'd2);
      chk("tmo_addr",    err_addr,     32'hFFFF_F070);

      // Ack in the 15th ACCESS cycle wins over the timeout
      txn(32'hFFFF_F072, 1'b0, 32'h0, 14, 32'h3333_4444);
      chk("ack15_latency", 32'(rdy_rel), 32'd16);
      chk("ack15_err",     32'(rdy_err), 32'h0);
      chk("ack15_rdata",   rdy_rdata,    32'h3333_4444);

      // Offset larger than the address wraps modulo 2^32
      txn(32'h0000_0100, 1'b1, 32'hA5A5_0001, 1, 32'h0);
      chk("wrap_s_addr", snap_addr, 32'hFFFF_C100);

      // 256 decode misses saturate the error counter
      for (int i = 0; i < 256; i++) txn(32'h0020_0000 + 32'(i), 1'b0, 32'h0, 0, 32'h0);
      chk("sat_cnt",  32'(err_cnt), 32'd255);
      chk("sat_addr", err_addr,     32'h0020_00FF);

      // Reset in the second ACCESS cycle of a slave 0 read
      rdy_seen       = 1'b0;
      bus_if.m_req   = 1'b1;
      bus_if.m_we    = 1'b0;
      bus_if.m_addr  = 32'h0000_4020;
      bus_if.m_wdata = 32'h0000_1234;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
         exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 4'h1, 1'b0, 32'h0000_0020, 32'h0000_1234, 1'b1,
                            cur_ecnt, cur_eaddr));
      bus_if.m_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      cur_ecnt  = 8'd0;
      cur_eaddr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rstmid_ready",   32'(rdy_seen),    32'h0);
      chk("rstmid_s_addr",  bus_if.s_addr,    32'h0);
      chk("rstmid_s_wdata", bus_if.s_wdata,   32'h0);
      chk("rstmid_err_cnt", 32'(err_cnt),     32'h0);

      // Normal read after the aborted transfer
      txn(32'hFFFF_F000, 1'b0, 32'h0, 2, 32'h0BAD_F00D);
      chk("post_latency", 32'(rdy_rel), 32'd4);
      chk("post_rdata",   rdy_rdata,    32'h0BAD_F00D);
      chk("post_err",     32'(rdy_err), 32'h0);

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mmio_bus.md
MMIO_BUS -- requirements
Module: mmio_bus

Interface
REQ-001 Parameter N_SLV, default 4: number of slave ports, 1..8.
REQ-002 Parameter SLV_BASE, default {FFFF_F070, FFFF_F060, FFFF_F000, 0000_0000} (slave 3..0, packed N_SLV*32): match value per slave.
REQ-003 Parameter SLV_MASK, default {FFFF_FFFC, FFFF_FFFC, FFFF_FFFC, FFE0_0000}: address bits compared per slave.
REQ-004 Parameter SLV_OFF, default {0, 0, 0, 0000_4000}: value subtracted from the address before it is driven to the slave.
REQ-005 Parameter TIMEOUT, default 15: maximum ACCESS cycles without ack, 1..255.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 m_req  in  1  master request, sampled in IDLE only.
REQ-009 m_we  in  1  1 = write, 0 = read.
REQ-010 m_addr  in  32  byte address.
REQ-011 m_wdata  in  32  write data.
REQ-012 m_ready  out  1  one-cycle completion strobe.
REQ-013 m_rdata  out  32  read data, valid while m_ready=1.
REQ-014 m_err  out  1  qualifies m_ready: 1 = decode miss or timeout.
REQ-015 s_sel  out  N_SLV  one-hot slave select.
REQ-016 s_we  out  1  latched m_we, gated by any s_sel.
REQ-017 s_addr  out  32  latched address minus SLV_OFF of the selected slave.
REQ-018 s_wdata  out  32  latched write data.
REQ-019 s_rdata  in  N_SLV*32  packed slave read data.
REQ-020 s_ack  in  N_SLV  per-slave completion.
REQ-021 err_addr  out  32  address of the most recent errored request.
REQ-022 err_cnt  out  8  saturating error count.

Function
REQ-023 Slave i SHALL hit when (addr & SLV_MASK[i]) == SLV_BASE[i]; when several slaves hit, the lowest index wins; no hit is a decode miss.
REQ-024 The FSM SHALL have the states IDLE, ACCESS, DONE and ERR.
REQ-025 In IDLE with m_req=1, the block SHALL latch addr, we and wdata and go to ACCESS on a hit, or to ERR on a miss.
REQ-026 In ACCESS, s_sel SHALL be one-hot on the decoded slave and s_we, s_addr and s_wdata SHALL come from the latched values.
REQ-027 In ACCESS, s_ack of the selected slave SHALL capture s_rdata (0 for writes) and move to DONE; acks from unselected slaves SHALL be ignored.
REQ-028 The timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; reaching TIMEOUT SHALL move to ERR, and an ack in that same cycle SHALL win, giving DONE.
REQ-029 DONE SHALL drive m_ready=1, m_err=0 and the captured m_rdata for one cycle, then go to IDLE.
REQ-030 ERR SHALL drive m_ready=1, m_err=1 and m_rdata=0 for one cycle, update err_addr, increment err_cnt (holding at 255), then go to IDLE.
REQ-031 Outside DONE and ERR, m_ready SHALL be 0 and m_rdata SHALL be 0; s_sel SHALL be 0 outside ACCESS.
REQ-032 m_req and master input changes SHALL be ignored in ACCESS, DONE and ERR; a request held high SHALL be accepted again in the IDLE cycle after m_ready.
REQ-033 Latency: with the request sampled at edge 0 and ack in the first ACCESS cycle, m_ready SHALL be high in cycle 2; each ack wait cycle adds one cycle.
REQ-034 The subtraction for s_addr SHALL be modulo 2^32.

Reset
REQ-035 When rst=1, the block SHALL go to IDLE and clear m_ready, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata, err_addr, err_cnt and the timeout counter by the next edge.
REQ-036 Reset mid-ACCESS SHALL abort the transfer with no m_ready pulse, and s_sel SHALL be 0 in the cycle after the reset edge.

Verification
REQ-037 Read 0x0000_4010 with slave 0 acking immediately and s_rdata0=0xDEAD_BEEF -> s_addr=0x10, m_ready with m_rdata=0xDEAD_BEEF in cycle 2, m_err=0.
REQ-038 Write 0xFFFF_F060 data 0x5A with slave 2 acking after 3 waits -> s_sel=0100, s_wdata=0x5A, m_ready in cycle 5, m_rdata=0.
REQ-039 Read 0x8000_0000 -> ERR; m_ready=1, m_err=1 in cycle 1; err_addr=0x8000_0000; err_cnt=1.
REQ-040 Slave 3 never acks, TIMEOUT=15 -> m_err pulse after 15 ACCESS cycles; repeat with ack on cycle 15 -> DONE, no error.
REQ-041 Assert rst during ACCESS on slave 0 -> no m_ready, s_sel=0, err_cnt=0; then a new read completes normally.
REQ-042 Force 256 decode misses -> err_cnt holds at 255.
